// File: rtl/d_trig_wr_arb.sv
// d_trig_wr_arb
// Round-robin write arbiter and sequencer for a shared WIDTH-bit register
// bank built from synchronous-reset D-trigger cells. One requester at a time
// owns the bank; the owner's load/clear commands become registered bank
// controls (data, load strobe, synchronous-reset strobe).
//
// Ports:
//   C          in   clock, rising edge
//   R          in   asynchronous active-low reset
//   req        in   [NREQ]        ownership request, level
//   wr_en      in   [NREQ]        load command (owner only)
//   clr        in   [NREQ]        clear command (owner only, beats wr_en)
//   wr_data    in   [NREQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   gnt        out  [NREQ]        one-hot registered grant
//   busy       out                high while a grant is active
//   bank_D     out  [WIDTH]       registered data to the bank D inputs
//   bank_load  out                one-cycle load strobe
//   bank_R     out                one-cycle synchronous-reset strobe (active high)
//
// Optional feature: define ARB_TIMEOUT_EN to force release after HOLD_MAX
// consecutive granted cycles and mask the released requester until it
// drops req for a cycle. Without it HOLD_MAX is unused.
module d_trig_wr_arb #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                    C,
  input  logic                    R,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         wr_en,
  input  logic [NREQ-1:0]         clr,
  input  logic [NREQ*WIDTH-1:0]   wr_data,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [WIDTH-1:0]        bank_D,
  output logic                    bank_load,
  output logic                    bank_R
);

  localparam int IW = $clog2(NREQ);

  // Reject configurations the arbiter is not built for.
  if (NREQ < 2 || NREQ > 8 || HOLD_MAX < 1) begin : g_bad_cfg
    $error("d_trig_wr_arb: NREQ must be 2..8 and HOLD_MAX >= 1");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q,   ptr_d;
  logic [NREQ-1:0]   gnt_q,   gnt_d;
  logic              busy_q,  busy_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic              load_q,  load_d;
  logic              rst_q,   rst_d;
  logic [NREQ-1:0]   elig_s;
  logic [IW-1:0]     sel_s;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0]     hold_q, hold_d;
  logic [NREQ-1:0]   mask_q, mask_d;
`endif

  // First set bit of elig at or above ptr, wrapping at NREQ-1 back to 0.
  // The extra index bit keeps ptr+i from overflowing before the wrap.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] elig,
                                            input logic [IW-1:0]   ptr);
    logic [IW:0]   cand;
    logic [IW-1:0] pick;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end else begin
        cand = cand;
      end
      if (!found && elig[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign bank_D    = data_q;
  assign bank_load = load_q;
  assign bank_R    = rst_q;

  // Eligibility: timed-out requesters stay masked until they drop req.
`ifdef ARB_TIMEOUT_EN
  assign elig_s = req & ~mask_q;
`else
  assign elig_s = req;
`endif

  assign sel_s = rr_pick(elig_s, ptr_q);

  // Next-state, grant and bank-control decode.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    data_d  = data_q;
    load_d  = 1'b0;
    rst_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    // A mask bit drops once its requester is seen with req low.
    mask_d  = mask_q & req;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|elig_s) begin
          state_d = ST_OWN;
          owner_d = sel_s;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel_s;
          busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end

      ST_OWN: begin
        // Commands are executed even on the releasing cycle.
        if (gnt_q[owner_q]) begin
          if (clr[owner_q]) begin
            rst_d  = 1'b1;
            data_d = '0;
          end else if (wr_en[owner_q]) begin
            load_d = 1'b1;
            data_d = wr_data[owner_q*WIDTH +: WIDTH];
          end else begin
            data_d = data_q;
          end
        end else begin
          data_d = data_q;
        end

        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + IW'(1);
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HW'(HOLD_MAX-1)) begin
          state_d         = ST_IDLE;
          gnt_d           = '0;
          busy_d          = 1'b0;
          ptr_d           = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + IW'(1);
          mask_d[owner_q] = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
`else
        else begin
          state_d = ST_OWN;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears grant and strobes at once.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      load_q  <= 1'b0;
      rst_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      load_q  <= load_d;
      rst_q   <= rst_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      mask_q  <= mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_d_trig_wr_arb.sv
// Directed bench for d_trig_wr_arb (NREQ=4, WIDTH=8, HOLD_MAX=4).
// Inputs change and outputs are sampled on the falling edge of C.
module tb_d_trig_wr_arb;

  logic        C;
  logic        R;
  logic [3:0]  req;
  logic [3:0]  wr_en;
  logic [3:0]  clr;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  bank_D;
  logic        bank_load;
  logic        bank_R;

  int checks = 0;
  int errors = 0;

  d_trig_wr_arb #(.NREQ(4), .WIDTH(8), .HOLD_MAX(4)) dut (
    .C(C), .R(R), .req(req), .wr_en(wr_en), .clr(clr), .wr_data(wr_data),
    .gnt(gnt), .busy(busy), .bank_D(bank_D), .bank_load(bank_load),
    .bank_R(bank_R)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic do_reset();
    req = 4'b0000; wr_en = 4'b0000; clr = 4'b0000; wr_data = 32'h0;
    R = 1'b0;
    repeat (2) @(negedge C);
    R = 1'b1;
    @(negedge C);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || bank_load !== 1'b0 || bank_R !== 1'b0 || bank_D !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got gnt=%b busy=%b ld=%b r=%b d=%h exp all zero", gnt, busy, bank_load, bank_R, bank_D);
    end
    // Grant requester 2, issue a load, then reset while the strobe is out.
    req = 4'b0100;
    @(negedge C);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL reset_pre_gnt got %b exp %b", gnt, 4'b0100); end
    wr_en = 4'b0100; wr_data = 32'h00FF_0000;
    @(posedge C);
    #2;
    R = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || bank_load !== 1'b0 || bank_R !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got gnt=%b busy=%b ld=%b r=%b exp 0000 0 0 0", gnt, busy, bank_load, bank_R);
    end
    req = 4'b0000; wr_en = 4'b0000; wr_data = 32'h0;
    @(negedge C);
    R = 1'b1;
    repeat (3) @(negedge C);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || bank_load !== 1'b0 || bank_R !== 1'b0 || bank_D !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle got gnt=%b busy=%b ld=%b r=%b d=%h exp all zero", gnt, busy, bank_load, bank_R, bank_D);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    req = 4'b0001;
    @(negedge C);
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL sw_gnt got %b/%b exp 0001/1", gnt, busy); end
    wr_en = 4'b0001; wr_data = 32'h0000_00A5;
    @(negedge C);
    checks++;
    if (bank_load !== 1'b1 || bank_D !== 8'hA5 || bank_R !== 1'b0) begin
      errors++; $display("FAIL sw_strobe got ld=%b d=%h r=%b exp 1 a5 0", bank_load, bank_D, bank_R);
    end
    wr_en = 4'b0000;
    @(negedge C);
    checks++;
    if (bank_load !== 1'b0 || bank_D !== 8'hA5) begin
      errors++; $display("FAIL sw_single got ld=%b d=%h exp 0 a5", bank_load, bank_D);
    end
    req = 4'b0000;
    @(negedge C);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL sw_release got %b/%b exp 0000/0", gnt, busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    @(negedge C);
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      checks++;
      if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt%0d got %b exp %b", k, gnt, exp_g); end
      @(negedge C);
      checks++;
      if (gnt !== exp_g) begin errors++; $display("FAIL rr_hold%0d got %b exp %b", k, gnt, exp_g); end
      req = 4'b1111 & ~exp_g;
      @(negedge C);
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rr_idle%0d got %b/%b exp 0000/0", k, gnt, busy); end
      req = 4'b1111;
      @(negedge C);
    end
    req = 4'b0000;
    repeat (3) @(negedge C);
  endtask

  task automatic test_priority_filter();
    do_reset();
    req = 4'b0010;
    @(negedge C);
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL pf_gnt got %b exp 0010", gnt); end
    wr_en = 4'b0010; clr = 4'b0010; wr_data = 32'h0000_7700;
    @(negedge C);
    checks++;
    if (bank_R !== 1'b1 || bank_load !== 1'b0 || bank_D !== 8'h00) begin
      errors++; $display("FAIL pf_clr_wins got r=%b ld=%b d=%h exp 1 0 00", bank_R, bank_load, bank_D);
    end
    wr_en = 4'b1000; clr = 4'b0000; wr_data = 32'h1100_0000; req = 4'b1010;
    @(negedge C);
    checks++;
    if (bank_R !== 1'b0 || bank_load !== 1'b0 || gnt !== 4'b0010) begin
      errors++; $display("FAIL pf_nonowner got r=%b ld=%b gnt=%b exp 0 0 0010", bank_R, bank_load, gnt);
    end
    @(negedge C);
    checks++;
    if (bank_load !== 1'b0 || bank_D !== 8'h00) begin
      errors++; $display("FAIL pf_nonowner2 got ld=%b d=%h exp 0 00", bank_load, bank_D);
    end
    req = 4'b0000; wr_en = 4'b0000;
    repeat (2) @(negedge C);
  endtask

  task automatic test_release_with_cmd();
    do_reset();
    req = 4'b1100;
    @(negedge C);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL rel_gnt got %b exp 0100", gnt); end
    req = 4'b1000; wr_en = 4'b0100; wr_data = 32'h003C_0000;
    @(negedge C);
    checks++;
    if (gnt !== 4'b0000 || bank_load !== 1'b1 || bank_D !== 8'h3C) begin
      errors++; $display("FAIL rel_same_edge got gnt=%b ld=%b d=%h exp 0000 1 3c", gnt, bank_load, bank_D);
    end
    wr_en = 4'b0000;
    @(negedge C);
    checks++;
    if (gnt !== 4'b1000 || bank_load !== 1'b0) begin
      errors++; $display("FAIL rel_next got gnt=%b ld=%b exp 1000 0", gnt, bank_load);
    end
    req = 4'b0000;
    repeat (2) @(negedge C);
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0011;
    @(negedge C);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL to_own0_c%0d got %b exp 0001", k, gnt); end
      @(negedge C);
    end
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL to_idle0 got %b exp 0000", gnt); end
    @(negedge C);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (gnt !== 4'b0010) begin errors++; $display("FAIL to_own1_c%0d got %b exp 0010", k, gnt); end
      @(negedge C);
    end
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL to_idle1 got %b exp 0000", gnt); end
    @(negedge C);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL to_masked got %b exp 0000", gnt); end
    req = 4'b0010;
    @(negedge C);
    req = 4'b0011;
    @(negedge C);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL to_regrant0 got %b exp 0001", gnt); end
`else
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL to_persist_c%0d got %b exp 0001", k, gnt); end
      @(negedge C);
    end
`endif
    req = 4'b0000;
    repeat (2) @(negedge C);
  endtask

  initial begin
    R = 1'b0; req = 4'b0000; wr_en = 4'b0000; clr = 4'b0000; wr_data = 32'h0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_priority_filter();
    test_release_with_cmd();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
